// File: rtl/dm_port_arbiter.sv
// Arbiter sharing the single-port DataMemory RAM between the pipeline (port 0) and a loader/debug master (port 1).
// Optional build macro: DM_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed priority with anti-starvation.
module dm_port_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int WAIT_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          stall0,
    output logic          rvalid0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    localparam int CW = 4;

    logic gnt0_c;
    logic gnt1_c;

`ifdef DM_ARB_ROUND_ROBIN_EN
    logic rr_last;

    // Contended cycles go to the port that did not win last time.
    always_comb begin
        gnt1_c = req1 & (~req0 | ~rr_last);
        gnt0_c = req0 & ~gnt1_c;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_last <= 1'b0;
        end else if (gnt0_c | gnt1_c) begin
            rr_last <= gnt1_c;
        end
    end
`else
    logic [CW-1:0] wait_cnt;
    logic          force1;

    // Port 0 wins unless port 1 has been refused WAIT_MAX cycles in a row.
    always_comb begin
        force1 = (wait_cnt == CW'(WAIT_MAX)) & req1;
        gnt1_c = req1 & (~req0 | force1);
        gnt0_c = req0 & ~gnt1_c;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (~req1 | gnt1_c) begin
            wait_cnt <= '0;
        end else if (wait_cnt != CW'(WAIT_MAX)) begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end
`endif

    always_comb begin
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        if (gnt0_c) begin
            mem_en   = 1'b1;
            mem_we   = we0;
            mem_addr = addr0;
            mem_din  = wdata0;
        end else if (gnt1_c) begin
            mem_en   = 1'b1;
            mem_we   = we1;
            mem_addr = addr1;
            mem_din  = wdata1;
        end
    end

    assign gnt0   = gnt0_c;
    assign gnt1   = gnt1_c;
    assign stall0 = req0 & ~gnt0_c;
    assign rdata  = mem_dout;

    // RAM read latency is one cycle, so valid follows the granted read by one clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            rvalid0 <= gnt0_c & ~we0;
            rvalid1 <= gnt1_c & ~we1;
        end
    end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: vector table for grants/memory bus, read-data scoreboard, reset corner cases.
module tb_dm_port_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, we0, req1, we1;
    logic [7:0] addr0, wdata0, addr1, wdata1;
    logic       gnt0, stall0, rvalid0, gnt1, rvalid1;
    logic [7:0] rdata;
    logic       mem_en, mem_we;
    logic [7:0] mem_addr, mem_din;
    logic [7:0] mem_dout;

    dm_port_arbiter #(.AW(8), .DW(8), .WAIT_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .stall0(stall0), .rvalid0(rvalid0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input int i);
        return (i == 'h10) ? 8'h5A : 8'(i ^ 8'hC3);
    endfunction

    // Behavioural single-port RAM standing in for DataMemory.
    logic [7:0] ram [256];
    logic       ram_loaded = 1'b0;
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
            ram_loaded <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_din;
            else        mem_dout <= ram[mem_addr];
        end
    end

    logic [7:0] ref_mem [256];

    typedef struct {
        logic       r0, w0;
        logic [7:0] a0, d0;
        logic       r1, w1;
        logic [7:0] a1, d1;
        logic       eg0, eg1;
    } vec_t;

    typedef struct {
        logic       port;
        logic [7:0] data;
    } rd_t;

    vec_t vecs[$];
    rd_t  sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic vec_t mk(input logic r0, w0, input logic [7:0] a0, d0,
                                input logic r1, w1, input logic [7:0] a1, d1,
                                input logic eg0, eg1);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.eg0 = eg0; v.eg1 = eg1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic check_rvalid();
        logic e0, e1;
        e0 = (sb.size() > 0) && (sb[0].port == 1'b0);
        e1 = (sb.size() > 0) && (sb[0].port == 1'b1);
        chk("rvalid0", 32'(rvalid0), 32'(e0));
        chk("rvalid1", 32'(rvalid1), 32'(e1));
        if (sb.size() > 0) begin
            chk("rdata", 32'(rdata), 32'(sb[0].data));
            void'(sb.pop_front());
        end
    endtask

    task automatic drive(input vec_t v);
        req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
        req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
    endtask

    task automatic step(input vec_t v);
        logic [17:0] exp_bus;
        rd_t         e;
        @(negedge clk);
        check_rvalid();
        drive(v);
        #1;
        chk("gnt0", 32'(gnt0), 32'(v.eg0));
        chk("gnt1", 32'(gnt1), 32'(v.eg1));
        chk("stall0", 32'(stall0), 32'(v.r0 & ~v.eg0));
        if (v.eg0)      exp_bus = {1'b1, v.w0, v.a0, v.d0};
        else if (v.eg1) exp_bus = {1'b1, v.w1, v.a1, v.d1};
        else            exp_bus = '0;
        chk("mem_bus", 32'({mem_en, mem_we, mem_addr, mem_din}), 32'(exp_bus));
        if (v.eg0) begin
            if (v.w0) ref_mem[v.a0] = v.d0;
            else begin e.port = 1'b0; e.data = ref_mem[v.a0]; sb.push_back(e); end
        end else if (v.eg1) begin
            if (v.w1) ref_mem[v.a1] = v.d1;
            else begin e.port = 1'b1; e.data = ref_mem[v.a1]; sb.push_back(e); end
        end
    endtask

    vec_t idle, rd0, both;
    logic post_rst_exp [5];

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        idle = mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0);
        rd0  = mk(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0);
        drive(idle);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_rvalid0", 32'(rvalid0), 32'd0);
        chk("rst_rvalid1", 32'(rvalid1), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        reset = 1'b0;

`ifdef DM_ARB_ROUND_ROBIN_EN
        both = mk(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00, 0, 0);
        vecs.push_back(idle);
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00, (i % 2) == 1, (i % 2) == 0));
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'h33, 0, 1));
        vecs.push_back(mk(1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0));
        vecs.push_back(mk(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00, 0, 1));
        vecs.push_back(idle);
        post_rst_exp = '{1, 0, 1, 0, 1};
`else
        both = mk(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00, 0, 0);
        vecs.push_back(idle);
        vecs.push_back(rd0);
        vecs.push_back(idle);
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'h33, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0, 8'h20, 8'h00, 0, 1));
        vecs.push_back(mk(1, 1, 8'h10, 8'hA5, 0, 0, 8'h00, 8'h00, 1, 0));
        vecs.push_back(mk(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0));
        // Contention: four refusals then a forced port-1 grant, twice.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++)
                vecs.push_back(mk(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00, 1, 0));
            vecs.push_back(mk(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00, 0, 1));
        end
        // Port 1 drops after three refusals; the count restarts from zero.
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00, 1, 0));
        vecs.push_back(mk(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00, 1, 0));
        vecs.push_back(mk(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00, 0, 1));
        vecs.push_back(mk(1, 1, 8'h30, 8'h11, 1, 0, 8'h30, 8'h00, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0, 8'h30, 8'h00, 0, 1));
        vecs.push_back(idle);
        post_rst_exp = '{0, 0, 0, 0, 1};
`endif

        foreach (vecs[i]) step(vecs[i]);

        // Reset while a granted read is in flight.
        step(rd0);
        @(posedge clk);
        #1;
        chk("inflight_rvalid0", 32'(rvalid0), 32'd1);
        reset = 1'b1;
        #1;
        chk("async_clr_rvalid0", 32'(rvalid0), 32'd0);
        sb.delete();
        @(negedge clk);
        drive(idle);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            both.eg1 = post_rst_exp[i];
            both.eg0 = ~post_rst_exp[i];
            step(both);
        end
        step(idle);
        step(idle);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
